vx_afu_run_ctrl: RTL
====================

Name: vx_afu_run_ctrl

Overview:
- Generalised AFU kernel run controller for the XRT AFU.
- Sequences core reset, run, drain and done across NUM_BANKS AXI memory ports.
- Tracks outstanding writes (AW plus last W beat matched, minus B) and outstanding reads (AR minus RLAST) per bank.
- Raises ap_done only once every bank is quiescent; flags counter overflow/underflow as a sticky error.

Parameters:
- NUM_BANKS, 1, number of AXI memory banks monitored (1..16).
- PENDING_SIZEW, 12, width of each per-bank pending write/read counter.
- RESET_DELAY, 16, cycles vx_reset is held after ap_start (>=1).
- WCREDIT_SIZEW, 4, width of the per-bank unmatched AW/WLAST credit counters.
- TIMEOUT_W, 32, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  kernel clock.
- reset  in  1  synchronous active-high reset.
- ap_start  in  1  start pulse from the control register block.
- ap_reset  in  1  soft reset pulse from the control register block.
- ap_ctrl_read  in  1  host read of the control register.
- ap_idle  out  1  state==IDLE.
- ap_done  out  1  state==DONE.
- ap_ready  out  1  equals ap_done.
- vx_reset  out  1  reset to the processor core.
- vx_busy  in  1  processor busy.
- awfire  in  NUM_BANKS  per-bank AW handshake (valid&&ready).
- wlastfire  in  NUM_BANKS  per-bank W handshake with wlast.
- bfire  in  NUM_BANKS  per-bank B handshake.
- arfire  in  NUM_BANKS  per-bank AR handshake.
- rlastfire  in  NUM_BANKS  per-bank R handshake with rlast.
- pending_wr  out  NUM_BANKS*PENDING_SIZEW  per-bank outstanding writes, bank 0 in the LSBs.
- pending_rd  out  NUM_BANKS*PENDING_SIZEW  per-bank outstanding reads.
- quiescent  out  1  all pending counters zero and all write credits zero.
- error  out  1  sticky counter overflow or underflow.

Behaviour:
- Reset values: state IDLE, vx_reset=1, all counters and credits 0, error=0, ap_idle=1, ap_done=0, ap_ready=0, quiescent=1.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE -> INIT on ap_start: load reset counter with RESET_DELAY-1; vx_reset stays 1.
- INIT:
  - Counter decrements each cycle; when it reads 0, vx_reset deasserts on the next edge.
  - With vx_reset=0, vx_busy=1 -> RUN.
  - vx_busy already high on the deassert cycle is sampled on the next cycle.
- RUN -> DRAIN when vx_busy=0.
- DRAIN -> DONE when quiescent=1; DRAIN lasts a single cycle if already quiescent.
- DONE -> IDLE when ap_ctrl_read=1 (done acknowledge).
  - ap_done is registered on the state, so it asserts one cycle after quiescent is reached.
- ap_reset in any state: state becomes IDLE and vx_reset becomes 1. Pending counters, credits and error are not cleared, so in-flight responses are still counted. reset clears everything.
- ap_start is ignored outside IDLE.
- Write-transaction completion: sub-module per bank.
  - Holds aw_credit and w_credit counters.
  - When awfire and wlastfire fire together, or one fires while the opposite credit is nonzero, tx_ack=1 the same cycle and the opposite credit decrements. Otherwise the firing side's credit increments.
- Per-bank pending_wr update: += tx_ack, -= bfire; simultaneous inc and dec leaves it unchanged.
- Per-bank pending_rd update: += arfire, -= rlastfire; same rule.
- Counter at max with increment only: counter holds, error sets.
- Counter or credit at 0 with decrement only: counter holds, error sets.
- A credit increment at max likewise holds and sets error.
- Outputs are combinational from registers; zero added latency from a fire to the counter update (registered next edge).

Optional Feature:
- Macro: VX_AFU_RUN_TIMEOUT_EN.
- When defined:
  - Adds input timeout_limit [TIMEOUT_W-1:0] and output timeout (sticky, cleared on reset or ap_start).
  - A watchdog counts cycles in RUN and DRAIN and clears on entering RUN.
  - If it reaches timeout_limit (limit 0 disables it), state goes to DONE, timeout=1, and vx_reset=1.
- When undefined: no such ports; RUN/DRAIN wait indefinitely.

Decomposition:
- Package vx_afu_run_pkg holds:
  - state enum afu_run_state_e (3 bits, IDLE=0..DONE=4);
  - a helper function for saturating signed update of a counter.
- Sub-module vx_axi_wr_tx_track, instanced per bank: inputs awfire, wlastfire; outputs tx_ack, overflow, underflow.

Test Plan:
- ap_start with RESET_DELAY=16, vx_busy high at cycle 18 -> vx_reset high exactly 16 cycles after the INIT entry edge, state RUN the following cycle, ap_idle=0.
- NUM_BANKS=2: bank1 gets 3 AW fires and then 3 WLAST fires 5 cycles later; vx_busy drops; B responses arrive 20 cycles later -> pending_wr[1] reaches 3 on the third WLAST, DRAIN holds until the third B, ap_done one cycle later.
- Same-cycle awfire+wlastfire+bfire on bank0 with pending_wr=1 -> pending_wr stays 1, credits stay 0, no error.
- 4 AR and 4 RLAST on bank0 interleaved with simultaneous fires -> pending_rd peaks at the expected value and returns to 0; DONE held until ap_ctrl_read, then IDLE.
- bfire with pending_wr=0 -> error=1 and counter stays 0. Separately, ap_reset in RUN with 2 writes pending -> IDLE, vx_reset=1, pending_wr stays 2 and later reaches 0 via B.
- With VX_AFU_RUN_TIMEOUT_EN, timeout_limit=100, vx_busy stuck high -> DONE with timeout=1 after 100 RUN cycles; timeout_limit=0 -> no timeout.

Source files
------------

// File: rtl/vx_afu_run_pkg.sv
// Shared types and helpers for the AFU kernel run controller.
// The run-controller state encoding and a saturating counter step helper
// live here so the top and the per-bank write tracker agree on them.
package vx_afu_run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } afu_run_state_e;

    // Outcome of one update of a saturating counter.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_ERR  = 2'd3
    } cnt_step_e;

    // Decide how a counter moves given a +1 request, a -1 request and its
    // current boundary status. Simultaneous +1/-1 cancel out; a step that
    // would wrap past either end is refused and reported as CNT_ERR, and the
    // caller holds its value in that case.
    function automatic cnt_step_e satStep(
        input logic inc,
        input logic dec,
        input logic atMax,
        input logic atZero
    );
        cnt_step_e step;
        step = CNT_HOLD;
        if (inc && !dec) begin
            step = atMax ? CNT_ERR : CNT_INC;
        end else if (dec && !inc) begin
            step = atZero ? CNT_ERR : CNT_DEC;
        end
        return step;
    endfunction

endpackage

// File: rtl/vx_afu_run_ctrl_wr_tx_track.sv
// Per-bank write-transaction completion tracker (module vx_axi_wr_tx_track).
// AW handshakes and last-W-beat handshakes can arrive in either order; a
// write counts as issued only once both halves have been seen. Unmatched
// halves are banked as credits; at most one of the two credits is ever
// nonzero, because any arrival first consumes an opposite credit.
module vx_axi_wr_tx_track
    import vx_afu_run_pkg::*;
#(
    parameter int WCREDIT_SIZEW = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic awfire,
    input  logic wlastfire,
    output logic tx_ack,
    output logic overflow,
    output logic underflow,
    output logic credits_zero
);

    logic [WCREDIT_SIZEW-1:0] r_awCredit;
    logic [WCREDIT_SIZEW-1:0] r_wCredit;
    logic                     w_awInc;
    logic                     w_awDec;
    logic                     w_wInc;
    logic                     w_wDec;
    cnt_step_e                w_awStep;
    cnt_step_e                w_wStep;

    // Pair this cycle's AW/WLAST arrivals with each other or with banked credits.
    always_comb begin
        tx_ack  = 1'b0;
        w_awInc = 1'b0;
        w_awDec = 1'b0;
        w_wInc  = 1'b0;
        w_wDec  = 1'b0;
        if (awfire && wlastfire) begin
            tx_ack = 1'b1;
        end else if (awfire) begin
            if (r_wCredit != '0) begin
                tx_ack = 1'b1;
                w_wDec = 1'b1;
            end else begin
                w_awInc = 1'b1;
            end
        end else if (wlastfire) begin
            if (r_awCredit != '0) begin
                tx_ack  = 1'b1;
                w_awDec = 1'b1;
            end else begin
                w_wInc = 1'b1;
            end
        end
    end

    assign w_awStep = satStep(w_awInc, w_awDec, &r_awCredit, r_awCredit == '0);
    assign w_wStep  = satStep(w_wInc, w_wDec, &r_wCredit, r_wCredit == '0);

    // Credit registers; a refused step leaves the credit unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awCredit <= '0;
            r_wCredit  <= '0;
        end else begin
            case (w_awStep)
                CNT_INC: r_awCredit <= r_awCredit + WCREDIT_SIZEW'(1);
                CNT_DEC: r_awCredit <= r_awCredit - WCREDIT_SIZEW'(1);
                default: r_awCredit <= r_awCredit;
            endcase
            case (w_wStep)
                CNT_INC: r_wCredit <= r_wCredit + WCREDIT_SIZEW'(1);
                CNT_DEC: r_wCredit <= r_wCredit - WCREDIT_SIZEW'(1);
                default: r_wCredit <= r_wCredit;
            endcase
        end
    end

    assign overflow     = ((w_awStep == CNT_ERR) && w_awInc) || ((w_wStep == CNT_ERR) && w_wInc);
    assign underflow    = ((w_awStep == CNT_ERR) && w_awDec) || ((w_wStep == CNT_ERR) && w_wDec);
    assign credits_zero = (r_awCredit == '0) && (r_wCredit == '0);

endmodule

// File: rtl/vx_afu_run_ctrl.sv
// AFU kernel run controller: sequences core reset, run, drain and done,
// and counts outstanding AXI reads/writes on every memory bank so ap_done
// only rises once all memory traffic has retired.
// Optional watchdog: define VX_AFU_RUN_TIMEOUT_EN to add timeout_limit and
// timeout ports; without it RUN and DRAIN wait indefinitely.
module vx_afu_run_ctrl
    import vx_afu_run_pkg::*;
#(
    parameter int NUM_BANKS     = 1,
    parameter int PENDING_SIZEW = 12,
    parameter int RESET_DELAY   = 16,
    parameter int WCREDIT_SIZEW = 4,
    parameter int TIMEOUT_W     = 32
)
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ap_start,
    input  logic                               ap_reset,
    input  logic                               ap_ctrl_read,
`ifdef VX_AFU_RUN_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0]               timeout_limit,
    output logic                               timeout,
`endif
    output logic                               ap_idle,
    output logic                               ap_done,
    output logic                               ap_ready,
    output logic                               vx_reset,
    input  logic                               vx_busy,
    input  logic [NUM_BANKS-1:0]               awfire,
    input  logic [NUM_BANKS-1:0]               wlastfire,
    input  logic [NUM_BANKS-1:0]               bfire,
    input  logic [NUM_BANKS-1:0]               arfire,
    input  logic [NUM_BANKS-1:0]               rlastfire,
    output logic [NUM_BANKS*PENDING_SIZEW-1:0] pending_wr,
    output logic [NUM_BANKS*PENDING_SIZEW-1:0] pending_rd,
    output logic                               quiescent,
    output logic                               error
);

    localparam int RstCntW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam logic [RstCntW-1:0] RstLoad = RstCntW'(RESET_DELAY - 1);

    afu_run_state_e       r_state;
    afu_run_state_e       w_stateNext;
    logic                 r_vxReset;
    logic [RstCntW-1:0]   r_resetCnt;
    logic                 r_error;
    logic                 w_enterInit;
    logic                 w_enterRun;
    logic                 w_wdogHit;
    logic                 w_timeoutHit;
    logic [NUM_BANKS-1:0] w_bankQuiet;
    logic [NUM_BANKS-1:0] w_bankErr;

    // Per-bank traffic accounting: write completion pairing plus pending counters.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [PENDING_SIZEW-1:0] r_wrCnt;
        logic [PENDING_SIZEW-1:0] r_rdCnt;
        logic                     w_txAck;
        logic                     w_credOvf;
        logic                     w_credUdf;
        logic                     w_credZero;
        cnt_step_e                w_wrStep;
        cnt_step_e                w_rdStep;

        vx_axi_wr_tx_track #(
            .WCREDIT_SIZEW (WCREDIT_SIZEW)
        ) u_wrTrack (
            .clk          (clk),
            .reset        (reset),
            .awfire       (awfire[g]),
            .wlastfire    (wlastfire[g]),
            .tx_ack       (w_txAck),
            .overflow     (w_credOvf),
            .underflow    (w_credUdf),
            .credits_zero (w_credZero)
        );

        assign w_wrStep = satStep(w_txAck, bfire[g], &r_wrCnt, r_wrCnt == '0);
        assign w_rdStep = satStep(arfire[g], rlastfire[g], &r_rdCnt, r_rdCnt == '0);

        // Pending counters survive ap_reset so late responses still retire.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wrCnt <= '0;
                r_rdCnt <= '0;
            end else begin
                case (w_wrStep)
                    CNT_INC: r_wrCnt <= r_wrCnt + PENDING_SIZEW'(1);
                    CNT_DEC: r_wrCnt <= r_wrCnt - PENDING_SIZEW'(1);
                    default: r_wrCnt <= r_wrCnt;
                endcase
                case (w_rdStep)
                    CNT_INC: r_rdCnt <= r_rdCnt + PENDING_SIZEW'(1);
                    CNT_DEC: r_rdCnt <= r_rdCnt - PENDING_SIZEW'(1);
                    default: r_rdCnt <= r_rdCnt;
                endcase
            end
        end

        assign pending_wr[g*PENDING_SIZEW +: PENDING_SIZEW] = r_wrCnt;
        assign pending_rd[g*PENDING_SIZEW +: PENDING_SIZEW] = r_rdCnt;
        assign w_bankQuiet[g] = (r_wrCnt == '0) && (r_rdCnt == '0) && w_credZero;
        assign w_bankErr[g]   = w_credOvf || w_credUdf ||
                                (w_wrStep == CNT_ERR) || (w_rdStep == CNT_ERR);
    end

    assign quiescent = &w_bankQuiet;

`ifdef VX_AFU_RUN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wdogCnt;
    logic                 r_timeout;

    assign w_wdogHit = ((r_state == RUN) || (r_state == DRAIN)) &&
                       (timeout_limit != '0) &&
                       (r_wdogCnt == timeout_limit - TIMEOUT_W'(1));

    // Watchdog: restarts on entering RUN, counts RUN/DRAIN cycles, sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdogCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enterRun) begin
                r_wdogCnt <= '0;
            end else if ((r_state == RUN) || (r_state == DRAIN)) begin
                r_wdogCnt <= r_wdogCnt + TIMEOUT_W'(1);
            end
            if (w_enterInit) begin
                r_timeout <= 1'b0;
            end else if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdogHit = 1'b0;
`endif

    // Next-state logic; ap_reset overrides every other transition.
    always_comb begin
        w_stateNext  = r_state;
        w_enterInit  = 1'b0;
        w_enterRun   = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    w_stateNext = INIT;
                    w_enterInit = 1'b1;
                end
            end
            INIT: begin
                if (!r_vxReset && vx_busy) begin
                    w_stateNext = RUN;
                    w_enterRun  = 1'b1;
                end
            end
            RUN: begin
                if (!vx_busy) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (quiescent) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (ap_ctrl_read) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        if (w_wdogHit) begin
            w_stateNext  = DONE;
            w_timeoutHit = 1'b1;
        end
        if (ap_reset) begin
            w_stateNext  = IDLE;
            w_enterInit  = 1'b0;
            w_enterRun   = 1'b0;
            w_timeoutHit = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Core reset: held for RESET_DELAY cycles after start, reasserted by soft reset or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vxReset  <= 1'b1;
            r_resetCnt <= '0;
        end else begin
            if (w_enterInit) begin
                r_resetCnt <= RstLoad;
            end else if ((r_state == INIT) && (r_resetCnt != '0)) begin
                r_resetCnt <= r_resetCnt - RstCntW'(1);
            end
            if (ap_reset || w_timeoutHit || w_enterInit) begin
                r_vxReset <= 1'b1;
            end else if ((r_state == INIT) && r_vxReset && (r_resetCnt == '0)) begin
                r_vxReset <= 1'b0;
            end
        end
    end

    // Sticky error collects any refused counter or credit step on any bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (|w_bankErr) begin
            r_error <= 1'b1;
        end
    end

    assign ap_idle  = (r_state == IDLE);
    assign ap_done  = (r_state == DONE);
    assign ap_ready = ap_done;
    assign vx_reset = r_vxReset;
    assign error    = r_error;

endmodule
